// File: rtl/neuron_pkg.sv
// Shared types and default widths for the neuron datapath and its sigmoid stage.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned DEF_ACT_W = 4;
    localparam int unsigned DEF_WGT_W = 8;
    localparam int unsigned DEF_ACC_W = 24;
    localparam int unsigned DEF_OUT_W = 8;

endpackage

// File: rtl/sat_clamp_fix.sv
// Arithmetic right shift of the accumulator, then clamp into the unsigned output range.
module sat_clamp_fix #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned SHIFT = 4,
    parameter int unsigned OUT_W = 8
) (
    input  logic signed [ACC_W-1:0] acc_in,
    output logic        [OUT_W-1:0] out_c
);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc_in >>> SHIFT;
        out_c   = shifted[OUT_W-1:0];
        if (shifted[ACC_W-1]) begin
            out_c = '0;
        end else if (|shifted[ACC_W-2:OUT_W]) begin
            out_c = '1;
        end
    end

endmodule

// File: rtl/neuron_mac_fix.sv
// One neuron: saturating MAC over N_INPUTS act/weight beats, then shift/clamp to OUT_W.
module neuron_mac_fix
    import neuron_pkg::*;
#(
    parameter int unsigned N_INPUTS = 784,
    parameter int unsigned ACT_W    = DEF_ACT_W,
    parameter int unsigned WGT_W    = DEF_WGT_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter int unsigned SHIFT    = 4,
    parameter int unsigned OUT_W    = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [ACC_W-1:0] bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [ACT_W-1:0] act,
    input  logic signed [WGT_W-1:0] weight,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [OUT_W-1:0] out_data
);

    localparam int unsigned CNT_W  = $clog2(N_INPUTS);
    localparam int unsigned PROD_W = ACT_W + WGT_W + 1;
    localparam int unsigned SUM_W  = ACC_W + PROD_W;
    localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic        [OUT_W-1:0] out_data_q, out_data_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc_sat;
    logic        [OUT_W-1:0]  clamp_c;

    // Sum is wide enough that neither operand can overflow before saturation.
    always_comb begin
        prod    = PROD_W'(signed'({1'b0, act})) * PROD_W'(weight);
        sum     = SUM_W'(acc_q) + SUM_W'(prod);
        acc_sat = ACC_W'(sum);
        if (sum > ACC_MAX) begin
            acc_sat = ACC_W'(ACC_MAX);
        end else if (sum < ACC_MIN) begin
            acc_sat = ACC_W'(ACC_MIN);
        end
    end

    // Clamp the post-beat value so out_data is ready alongside out_valid.
    sat_clamp_fix #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_clamp (
        .acc_in (acc_sat),
        .out_c  (clamp_c)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = bias;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_sat;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
                        state_d     = DONE;
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = clamp_c;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_neuron_mac_fix.sv
// Directed bench for neuron_mac_fix: 24-bit and 12-bit accumulator instances share stimulus.
module tb_neuron_mac_fix;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [23:0] bias;
    logic signed [11:0] bias_s;
    logic               in_valid;
    logic [3:0]         act;
    logic signed [7:0]  weight;
    logic               out_ready;
    logic               in_ready, out_valid;
    logic [7:0]         out_data;
    logic               in_ready_s, out_valid_s;
    logic [7:0]         out_data_s;

    int n_vec = 0;
    int n_err = 0;

    assign bias_s = bias[11:0];

    always #5 clk = ~clk;

    neuron_mac_fix #(
        .N_INPUTS (4), .ACT_W (4), .WGT_W (8), .ACC_W (24), .SHIFT (4), .OUT_W (8)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .bias (bias),
        .in_valid (in_valid), .in_ready (in_ready), .act (act), .weight (weight),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data)
    );

    neuron_mac_fix #(
        .N_INPUTS (4), .ACT_W (4), .WGT_W (8), .ACC_W (12), .SHIFT (4), .OUT_W (8)
    ) dut_s (
        .clk (clk), .rst_n (rst_n), .start (start), .bias (bias_s),
        .in_valid (in_valid), .in_ready (in_ready_s), .act (act), .weight (weight),
        .out_valid (out_valid_s), .out_ready (out_ready), .out_data (out_data_s)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_neuron(input logic signed [23:0] b);
        bias  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [3:0] a, input logic signed [7:0] w);
        in_valid = 1'b1;
        act      = a;
        weight   = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0;
        act = '0; weight = '0; out_ready = 1'b0;
        #12;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", 32'(out_data), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // basic sum: 16+15+30+45+60 = 166 -> 10
        start_neuron(24'sd16);
        check_val("accum_in_ready", 32'(in_ready), 32'd1);
        beat(4'd15, 8'sd1);
        beat(4'd15, 8'sd2);
        beat(4'd15, 8'sd3);
        check_val("basic_not_yet", 32'(out_valid), 32'd0);
        beat(4'd15, 8'sd4);
        check_val("basic_valid", 32'(out_valid), 32'd1);
        check_val("basic_data", 32'(out_data), 32'd10);
        check_val("done_in_ready", 32'(in_ready), 32'd0);
        drain();

        // negative clamp: 4 * -1920 -> 0
        start_neuron(24'sd0);
        for (int i = 0; i < 4; i++) beat(4'd15, -8'sd128);
        check_val("neg_valid", 32'(out_valid), 32'd1);
        check_val("neg_data", 32'(out_data), 32'd0);
        drain();

        // high clamp: 8000 + 4*1905 = 15620 -> 976 -> 255
        start_neuron(24'sd8000);
        for (int i = 0; i < 4; i++) beat(4'd15, 8'sd127);
        check_val("high_data", 32'(out_data), 32'd255);
        drain();

        // saturation: 12-bit acc pinned at 2047 -> 127; 24-bit sees 9667 -> 255
        start_neuron(24'sd2047);
        for (int i = 0; i < 4; i++) beat(4'd15, 8'sd127);
        check_val("sat_valid", 32'(out_valid_s), 32'd1);
        check_val("sat_data", 32'(out_data_s), 32'd127);
        check_val("sat_wide_data", 32'(out_data), 32'd255);
        drain();

        // backpressure: in_valid in IDLE ignored, gaps, held output, start in DONE ignored
        beat(4'd15, 8'sd127);
        check_val("idle_in_ready", 32'(in_ready), 32'd0);
        start_neuron(24'sd0);
        beat(4'd2, 8'sd3);
        tick();
        tick();
        beat(4'd4, 8'sd5);
        tick();
        beat(4'd6, 8'sd7);
        tick();
        tick();
        tick();
        beat(4'd8, 8'sd9);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) start = 1'b1;
            if (i == 2) bias = 24'sd1000;
            check_val("bp_valid_hold", 32'(out_valid), 32'd1);
            check_val("bp_data_hold", 32'(out_data), 32'd8);
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check_val("hs_start_valid", 32'(out_valid), 32'd0);
        check_val("hs_start_ignored", 32'(in_ready), 32'd0);

        // reset mid-operation
        start_neuron(24'sd500);
        beat(4'd15, 8'sd100);
        beat(4'd15, 8'sd100);
        rst_n = 1'b0;
        #1;
        check_val("midrst_in_ready", 32'(in_ready), 32'd0);
        check_val("midrst_out_data", 32'(out_data), 32'd0);
        check_val("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        beat(4'd1, 8'sd16);
        check_val("post_rst_no_beat", 32'(in_ready), 32'd0);
        start_neuron(24'sd0);
        for (int i = 0; i < 4; i++) beat(4'd1, 8'sd16);
        check_val("post_rst_valid", 32'(out_valid), 32'd1);
        check_val("post_rst_data", 32'(out_data), 32'd4);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
